// File: rtl/apb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// apb_irq_ctrl
// APB slave interrupt controller that merges the timer interrupt (source 0)
// and other peripheral interrupt lines into one registered core interrupt.
// Each source has its own IDLE -> PEND -> INSRV state machine. Software
// takes ownership of a source by reading CLAIM and returns it by writing
// its ID to COMPLETE.
//
// Ports:
//   PCLK     in   1        APB clock, the only clock
//   PRESETn  in   1        synchronous active-low reset
//   PSEL     in   1        APB select
//   PENABLE  in   1        APB access phase
//   PWRITE   in   1        1 = write
//   PADDR    in   [4:2]    word register select
//   PWDATA   in   32       write data
//   PRDATA   out  32       read data, combinational, 0 unless PSEL & !PWRITE
//   irq_src  in   NUM_SRC  active-high requests, bit 0 = timer TIMINT
//   irq_o    out  1        registered interrupt to the core
//
// Register map (PADDR[4:2]):
//   0 PENDING RO, 1 ENABLE RW, 2 TRIGGER RW (1 = edge), 3 CLAIM RO,
//   4 COMPLETE WO, 5-7 read 0 / writes ignored.
//
// Build option: define IRQ_SYNC_EN to place a 2-flop synchroniser on
// every irq_src bit. Each synchroniser adds 2 cycles of source latency.
// ---------------------------------------------------------------------------
module apb_irq_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [4:2]         PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        INSRV = 2'd2
    } src_state_t;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_ENABLE   = 3'd1;
    localparam logic [2:0] ADDR_TRIGGER  = 3'd2;
    localparam logic [2:0] ADDR_CLAIM    = 3'd3;
    localparam logic [2:0] ADDR_COMPLETE = 3'd4;

    logic               wr_fire;
    logic               claim_fire;
    logic               complete_fire;
    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_q_reg;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] trigger_reg;
    logic [NUM_SRC-1:0] pend_vec;
    logic [NUM_SRC-1:0] claim_pick;
    logic [NUM_SRC-1:0] claim_take;
    logic [ID_W-1:0]    claim_id;
    logic               claim_found;
    logic               irq_reg;
    logic               unused_pwdata;

    assign wr_fire       = PSEL & PENABLE & PWRITE;
    assign claim_fire    = PSEL & PENABLE & ~PWRITE & (PADDR == ADDR_CLAIM);
    assign complete_fire = wr_fire & (PADDR == ADDR_COMPLETE);
    assign unused_pwdata = ^PWDATA;

    // Source conditioning
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_reg;
    logic [NUM_SRC-1:0] sync2_reg;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_src;
            sync2_reg <= sync1_reg;
        end
    end

    assign src_s = sync2_reg;
`else
    assign src_s = irq_src;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            src_q_reg <= '0;
        end else begin
            src_q_reg <= src_s;
        end
    end

    assign edge_det = src_s & ~src_q_reg;
    // Request into IDLE: rising edge for edge sources, level otherwise.
    assign req_vec  = (trigger_reg & edge_det) | (~trigger_reg & src_s);

    // Configuration registers
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            enable_reg  <= '0;
            trigger_reg <= '0;
        end else if (wr_fire) begin
            if (PADDR == ADDR_ENABLE) begin
                enable_reg <= PWDATA[NUM_SRC-1:0];
            end
            if (PADDR == ADDR_TRIGGER) begin
                trigger_reg <= PWDATA[NUM_SRC-1:0];
            end
        end
    end

    // Fixed priority: lowest index among pending and enabled sources.
    always_comb begin
        claim_pick  = '0;
        claim_id    = '0;
        claim_found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!claim_found && pend_vec[i] && enable_reg[i]) begin
                claim_found   = 1'b1;
                claim_pick[i] = 1'b1;
                claim_id      = ID_W'(i + 1);
            end
        end
    end

    assign claim_take = claim_pick & {NUM_SRC{claim_fire}};

    // Per-source state machines
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            src_state_t state_reg;
            src_state_t state_next;
            logic       complete_hit;

            assign complete_hit = complete_fire &&
                                  (PWDATA[ID_W-1:0] == ID_W'(gi + 1));

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    IDLE: begin
                        if (req_vec[gi]) begin
                            state_next = PEND;
                        end
                    end
                    PEND: begin
                        if (claim_take[gi]) begin
                            state_next = INSRV;
                        end
                    end
                    INSRV: begin
                        // An edge landing on the completing cycle is kept;
                        // a level source re-pends from IDLE a cycle later.
                        if (complete_hit) begin
                            state_next = (trigger_reg[gi] & edge_det[gi]) ? PEND : IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end

            always_ff @(posedge PCLK) begin
                if (!PRESETn) begin
                    state_reg <= IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            assign pend_vec[gi] = (state_reg == PEND);
        end
    endgenerate

    // The source claimed this cycle is removed so irq_o drops on the next
    // cycle; newly latched requests only appear a cycle after they pend.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(pend_vec & enable_reg & ~claim_take);
        end
    end

    assign irq_o = irq_reg;

    // Read mux
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_PENDING: PRDATA = {{(32-NUM_SRC){1'b0}}, pend_vec};
                ADDR_ENABLE:  PRDATA = {{(32-NUM_SRC){1'b0}}, enable_reg};
                ADDR_TRIGGER: PRDATA = {{(32-NUM_SRC){1'b0}}, trigger_reg};
                ADDR_CLAIM:   PRDATA = {{(32-ID_W){1'b0}}, claim_id};
                default:      PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_irq_ctrl
// Directed self-checking bench for apb_irq_ctrl: reset, timer edge,
// priority with level sources, masking, complete/edge collision and reset
// during a claim. Source latencies follow the IRQ_SYNC_EN build option.
// ---------------------------------------------------------------------------
module tb_apb_irq_ctrl;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 5;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int K_COL = 2 + SYNC_LAT;

    logic               PCLK;
    logic               PRESETn;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [4:2]         PADDR;
    logic [31:0]        PWDATA;
    logic [31:0]        PRDATA;
    logic [NUM_SRC-1:0] irq_src;
    logic               irq_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] d;

    apb_irq_ctrl #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .irq_src (irq_src),
        .irq_o   (irq_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Zero-cycle read: PRDATA is combinational during the setup phase.
    task automatic peek(input logic [2:0] addr, output logic [31:0] data);
        PSEL    = 1'b1;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PADDR   = addr;
        #1;
        data = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic apb_write(input logic [2:0] addr, input logic [31:0] data);
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWDATA  = data;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        $display("APB write addr=%0d data=0x%08h", addr, data);
    endtask

    task automatic apb_read(input logic [2:0] addr, output logic [31:0] data);
        PSEL    = 1'b1;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PADDR   = addr;
        tick();
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        $display("APB read  addr=%0d data=0x%08h", addr, data);
    endtask

    initial begin
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        irq_src = 8'hFF;

        // T1 reset with all sources high
        tick();
        tick();
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        peek(3'd0, d); check("rst_pending", d, 32'd0);
        peek(3'd1, d); check("rst_enable", d, 32'd0);
        peek(3'd2, d); check("rst_trigger", d, 32'd0);
        check("rst_prdata_nosel", PRDATA, 32'd0);
        irq_src = '0;
        PRESETn = 1'b1;
        repeat (SYNC_LAT + 2) tick();
        check("post_rst_irq", {31'd0, irq_o}, 32'd0);

        // Register boundaries
        apb_write(3'd1, 32'hFFFF_FFFF);
        peek(3'd1, d); check("enable_upper_zero", d, 32'h0000_00FF);
        apb_write(3'd5, 32'h0000_1234);
        peek(3'd5, d); check("unused_addr", d, 32'd0);

        // T2 timer edge
        apb_write(3'd2, 32'h1);
        apb_write(3'd1, 32'h1);
        peek(3'd2, d); check("t2_trigger", d, 32'h1);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (SYNC_LAT) tick();
        peek(3'd0, d); check("t2_pending", d, 32'h1);
        check("t2_irq_not_yet", {31'd0, irq_o}, 32'd0);
        tick();
        check("t2_irq_rise", {31'd0, irq_o}, 32'd1);
        apb_read(3'd3, d); check("t2_claim", d, 32'd1);
        check("t2_irq_fall", {31'd0, irq_o}, 32'd0);
        peek(3'd0, d); check("t2_pending_after_claim", d, 32'd0);
        apb_write(3'd4, 32'd1);

        // T3 priority between level sources 2 and 3
        apb_write(3'd2, 32'h0);
        apb_write(3'd1, 32'h0C);
        irq_src = 8'h0C;
        repeat (SYNC_LAT + 2) tick();
        peek(3'd0, d); check("t3_pending", d, 32'h0C);
        check("t3_irq", {31'd0, irq_o}, 32'd1);
        apb_read(3'd3, d); check("t3_claim_a", d, 32'd3);
        check("t3_irq_other_pend", {31'd0, irq_o}, 32'd1);
        apb_read(3'd3, d); check("t3_claim_b", d, 32'd4);
        apb_read(3'd3, d); check("t3_claim_none", d, 32'd0);
        check("t3_irq_all_insrv", {31'd0, irq_o}, 32'd0);
        apb_write(3'd4, 32'd3);
        tick();
        peek(3'd0, d); check("t3_repend", d, 32'h04);
        apb_read(3'd3, d); check("t3_claim_again", d, 32'd3);
        irq_src = 8'h00;
        apb_write(3'd4, 32'd3);
        apb_write(3'd4, 32'd4);
        repeat (2) tick();
        peek(3'd0, d); check("t3_idle", d, 32'd0);

        // T4 masking
        apb_write(3'd1, 32'h0);
        apb_write(3'd2, 32'h20);
        irq_src = 8'h20;
        tick();
        irq_src = 8'h00;
        repeat (SYNC_LAT + 1) tick();
        peek(3'd0, d); check("t4_pending_masked", d, 32'h20);
        check("t4_irq_masked", {31'd0, irq_o}, 32'd0);
        apb_write(3'd1, 32'h20);
        check("t4_irq_pre", {31'd0, irq_o}, 32'd0);
        tick();
        check("t4_irq_unmasked", {31'd0, irq_o}, 32'd1);
        apb_read(3'd3, d); check("t4_claim", d, 32'd6);
        apb_write(3'd4, 32'd6);

        // T5 collision and ignored completes
        apb_write(3'd2, 32'h1);
        apb_write(3'd1, 32'h1);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (SYNC_LAT + 1) tick();
        check("t5_irq", {31'd0, irq_o}, 32'd1);
        apb_read(3'd3, d); check("t5_claim", d, 32'd1);
        apb_write(3'd4, 32'd0);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (SYNC_LAT + 2) tick();
        peek(3'd0, d); check("t5_insrv_edge_drop", d, 32'd0);
        check("t5_insrv_irq", {31'd0, irq_o}, 32'd0);
        // COMPLETE 1 commits on the same edge the new TIMINT edge is seen
        for (int k = 1; k <= K_COL; k++) begin
            if (k == K_COL - 1) begin
                PSEL    = 1'b1;
                PWRITE  = 1'b1;
                PENABLE = 1'b0;
                PADDR   = 3'd4;
                PWDATA  = 32'd1;
            end
            if (k == K_COL) PENABLE = 1'b1;
            if (k == K_COL - SYNC_LAT) irq_src = 8'h01;
            tick();
        end
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        irq_src = 8'h00;
        $display("APB write addr=4 data=0x00000001 with TIMINT edge");
        peek(3'd0, d); check("t5_collision_pend", d, 32'h1);
        tick();
        check("t5_collision_irq", {31'd0, irq_o}, 32'd1);
        apb_write(3'd4, 32'd7);
        peek(3'd0, d); check("t5_id7_pend", d, 32'h1);
        check("t5_id7_irq", {31'd0, irq_o}, 32'd1);
        apb_write(3'd4, 32'd1);
        peek(3'd0, d); check("t5_complete_in_pend", d, 32'h1);
        apb_read(3'd3, d); check("t5_claim2", d, 32'd1);
        apb_write(3'd4, 32'd1);

        // T6 reset asserted during a claim access
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (SYNC_LAT + 1) tick();
        check("t6_irq", {31'd0, irq_o}, 32'd1);
        PSEL    = 1'b1;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PADDR   = 3'd3;
        tick();
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        check("t6_irq_rst", {31'd0, irq_o}, 32'd0);
        check("t6_claim_rst", PRDATA, 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        #1;
        check("t6_prdata_nosel", PRDATA, 32'd0);
        peek(3'd0, d); check("t6_pending_rst", d, 32'd0);
        peek(3'd1, d); check("t6_enable_rst", d, 32'd0);
        peek(3'd2, d); check("t6_trigger_rst", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
